fifo_reader_e0: RTL

// Read-side controller for the e0 FIFO: pops words whenever the FIFO is non-empty and

---
 rtl/fifo_reader_e0_if.sv | 28 ++
 rtl/fifo_reader_e0.sv | 107 ++++++++++
 2 files changed

// File: rtl/fifo_reader_e0_if.sv
// Signal bundle between the e0 FIFO reader, its source FIFO and the downstream stage.
// master = the reader itself; slave = the surrounding source/sink logic.
interface fifo_reader_e0_if #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned CNT_SIZE  = 8
);
  logic                 enable;
  logic                 fifo_empty;
  logic [DATA_SIZE-1:0] fifo_data;
  logic                 fifo_error;
  logic                 pop;
  logic                 dest_pause;
  logic                 dest_push;
  logic [DATA_SIZE-1:0] dest_data;
  logic [CNT_SIZE-1:0]  pop_count;
  logic                 err_sticky;
  logic                 idle;

  modport master (
    input  enable, fifo_empty, fifo_data, fifo_error, dest_pause,
    output pop, dest_push, dest_data, pop_count, err_sticky, idle
  );

  modport slave (
    output enable, fifo_empty, fifo_data, fifo_error, dest_pause,
    input  pop, dest_push, dest_data, pop_count, err_sticky, idle
  );
endinterface

// File: rtl/fifo_reader_e0.sv
// Read-side controller for fifo_e0: pops while space exists, absorbs the one-cycle
// pop-to-data latency in a 2-entry skid buffer and forwards words with push/pause.
module fifo_reader_e0 #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned CNT_SIZE  = 8
) (
  input logic              clk,
  input logic              reset,
  fifo_reader_e0_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  state_e               state_q;
  logic [1:0]           occ_q, occ_d;
  logic                 inflight_q;
  logic [DATA_SIZE-1:0] skid_q [2];
  logic [DATA_SIZE-1:0] skid_d [2];
  logic [CNT_SIZE-1:0]  cnt_q;
  logic                 err_q;
  logic                 push_c;
  logic                 pop_c;
  logic [2:0]           fill_c;

  // A head word leaving this cycle frees its slot, so the pop gate counts it as
  // available; this keeps one pop per cycle while the sink accepts every word.
  always_comb begin
    push_c = (occ_q != 2'd0) && !bus.dest_pause;
    fill_c = 3'(occ_q) + 3'(inflight_q);
    pop_c  = (state_q == ST_RUN) && !bus.fifo_empty && (fill_c < (3'd2 + 3'(push_c)));
  end

  // Skid buffer: entry 0 is the head; captures land behind any remaining word.
  always_comb begin
    skid_d = skid_q;
    occ_d  = occ_q;
    case ({inflight_q, push_c})
      2'b01: begin
        skid_d[0] = skid_q[1];
        occ_d     = occ_q - 2'd1;
      end
      2'b10: begin
        skid_d[occ_q[0]] = bus.fifo_data;
        occ_d            = occ_q + 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          skid_d[0] = skid_q[1];
          skid_d[1] = bus.fifo_data;
        end else begin
          skid_d[0] = bus.fifo_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (bus.enable) state_q <= ST_RUN;
        ST_RUN: begin
          if (bus.fifo_error)   state_q <= ST_ERROR;
          else if (!bus.enable) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (bus.fifo_error)                          state_q <= ST_ERROR;
          else if ((occ_q == 2'd0) && !inflight_q)     state_q <= ST_IDLE;
        end
        ST_ERROR: state_q <= ST_ERROR;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= pop_c;
      skid_q     <= skid_d;
      cnt_q      <= cnt_q + CNT_SIZE'(pop_c);
      err_q      <= err_q | (bus.fifo_error && (state_q != ST_IDLE));
    end
  end

  assign bus.pop        = pop_c;
  assign bus.dest_push  = push_c;
  assign bus.dest_data  = (occ_q != 2'd0) ? skid_q[0] : '0;
  assign bus.pop_count  = cnt_q;
  assign bus.err_sticky = err_q;
  assign bus.idle       = (state_q == ST_IDLE);

endmodule
